sm83_bus_ctrl: RTL and testbench

SM83_BUS_CTRL -- requirements
Module: sm83_bus_ctrl

---
 rtl/sm83_bus_ctrl.sv | 124 ++++++++++++
 tb/tb_sm83_bus_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sm83_bus_ctrl.sv
// SM83 external bus controller: runs the T1..T4 M-cycle sequence, drives the
// memory strobes and stretches T3 with wait states until ready or a timeout.
module sm83_bus_ctrl #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_write,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic [1:0]  t_state,
   output logic        mc_done,
   output logic        bus_err,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {
      T1 = 2'd0,
      T2 = 2'd1,
      T3 = 2'd2,
      T4 = 2'd3
   } tstate_e;

   localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

   tstate_e     state_q, state_d;
   logic        req_q, req_d;
   logic        write_q, write_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        abort_q, abort_d;
   logic [7:0]  rdata_q, rdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= T1;
         req_q      <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         wait_cnt_q <= 8'h00;
         abort_q    <= 1'b0;
         rdata_q    <= 8'h00;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         abort_q    <= abort_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      abort_d    = abort_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         T1: begin
            // The core's request is captured only here; it is ignored elsewhere.
            state_d    = T2;
            req_d      = cpu_req;
            write_d    = cpu_write;
            addr_d     = cpu_addr;
            wdata_d    = cpu_wdata;
            wait_cnt_d = 8'h00;
            abort_d    = 1'b0;
         end
         T2: begin
            state_d = T3;
         end
         T3: begin
            if (!req_q || mem_ready) begin
               state_d = T4;
               if (req_q && !write_q) begin
                  rdata_d = mem_rdata;
               end
            end else if (wait_cnt_q < WAIT_MAX) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
               // Timeout: abandon the access; a read returns open-bus FF.
               state_d = T4;
               abort_d = 1'b1;
               if (!write_q) begin
                  rdata_d = 8'hFF;
               end
            end
         end
         T4: begin
            state_d    = T1;
            wait_cnt_d = 8'h00;
         end
         default: begin
            state_d = T1;
         end
      endcase
   end

   // Strobes and handshake decode purely from registered state, never mem_ready.
   assign t_state   = state_q;
   assign mc_done   = (state_q == T4);
   assign bus_err   = (state_q == T4) && abort_q;
   assign mem_rd    = req_q && !write_q && ((state_q == T2) || (state_q == T3));
   assign mem_wr    = req_q && write_q && (state_q == T3);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Directed bench for sm83_bus_ctrl with WAIT_LIMIT=4 so the timeout path is reachable.
module tb_sm83_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_write = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  cpu_rdata;
   logic [1:0]  t_state;
   logic        mc_done;
   logic        bus_err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_ready = 1'b1;

   int n_chk = 0;
   int n_fail = 0;

   sm83_bus_ctrl #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .t_state(t_state), .mc_done(mc_done), .bus_err(bus_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_chk++; if (t_state !== 2'd0) begin n_fail++; $display("FAIL rst_tstate got %0d want 0", t_state); end
      n_chk++; if ({mem_rd, mem_wr, mc_done, bus_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_ctrl got %b want 0000", {mem_rd, mem_wr, mc_done, bus_err}); end
      n_chk++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr got %h want 0000", mem_addr); end
      n_chk++; if ({mem_wdata, cpu_rdata} !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", {mem_wdata, cpu_rdata}); end
      #3 rst = 1'b0;
   endtask

   task automatic test_idle();
      cpu_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         n_chk++; if (t_state !== 2'(i % 4)) begin n_fail++; $display("FAIL idle_tstate[%0d] got %0d want %0d", i, t_state, i % 4); end
         n_chk++; if (mc_done !== (i % 4 == 3)) begin n_fail++; $display("FAIL idle_done[%0d] got %b want %b", i, mc_done, (i % 4 == 3)); end
         n_chk++; if ({mem_rd, mem_wr} !== 2'b00) begin n_fail++; $display("FAIL idle_strobe[%0d] got %b want 00", i, {mem_rd, mem_wr}); end
         tick();
      end
   endtask

   task automatic test_read();
      int rd_cyc = 0;
      int ticks = 0;
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'hC000; mem_rdata = 8'h5A; mem_ready = 1'b1;
      n_chk++; if (t_state !== 2'd0) begin n_fail++; $display("FAIL rd_start got %0d want 0", t_state); end
      while (ticks < 10) begin
         tick(); ticks++;
         if (ticks == 1) begin cpu_req = 1'b0; cpu_addr = 16'hDEAD; end
         if (mem_rd) rd_cyc++;
         if (t_state != 2'd0) begin
            n_chk++; if (mem_addr !== 16'hC000) begin n_fail++; $display("FAIL rd_addr got %h want c000", mem_addr); end
         end
         if (mc_done) break;
      end
      n_chk++; if (ticks + 1 !== 4) begin n_fail++; $display("FAIL rd_len got %0d want 4", ticks + 1); end
      n_chk++; if (rd_cyc !== 2) begin n_fail++; $display("FAIL rd_strobe got %0d want 2", rd_cyc); end
      n_chk++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_data got %h want 5a", cpu_rdata); end
      n_chk++; if ({mem_rd, bus_err} !== 2'b00) begin n_fail++; $display("FAIL rd_t4 got %b want 00", {mem_rd, bus_err}); end
      tick();
      n_chk++; if ({t_state, mc_done} !== 3'b000) begin n_fail++; $display("FAIL rd_end got %b want 000", {t_state, mc_done}); end
      n_chk++; if (mem_addr !== 16'hC000) begin n_fail++; $display("FAIL rd_hold got %h want c000", mem_addr); end
   endtask

   task automatic test_write_wait();
      int wr_cyc = 0;
      int t3 = 0;
      int ticks = 0;
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'hFF80; cpu_wdata = 8'h3C; mem_ready = 1'b0;
      while (ticks < 20) begin
         tick(); ticks++;
         if (ticks == 1) begin cpu_req = 1'b0; cpu_wdata = 8'h00; end
         if (t_state == 2'd2) t3++;
         if (t3 == 3) mem_ready = 1'b1;
         if (mem_wr) begin
            wr_cyc++;
            n_chk++; if ({mem_addr, mem_wdata} !== 24'hFF803C) begin n_fail++; $display("FAIL wr_bus got %h want ff803c", {mem_addr, mem_wdata}); end
         end
         if (mc_done) break;
      end
      n_chk++; if (ticks + 1 !== 6) begin n_fail++; $display("FAIL wr_len got %0d want 6", ticks + 1); end
      n_chk++; if (wr_cyc !== 3) begin n_fail++; $display("FAIL wr_strobe got %0d want 3", wr_cyc); end
      n_chk++; if ({bus_err, mem_wr} !== 2'b00) begin n_fail++; $display("FAIL wr_t4 got %b want 00", {bus_err, mem_wr}); end
      n_chk++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL wr_rdata_hold got %h want 5a", cpu_rdata); end
      tick();
   endtask

   task automatic test_abort();
      int rd_cyc = 0;
      int t3 = 0;
      int ticks = 0;
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h1234; mem_rdata = 8'h77; mem_ready = 1'b0;
      while (ticks < 20) begin
         tick(); ticks++;
         if (ticks == 1) cpu_req = 1'b0;
         if (t_state == 2'd2) t3++;
         if (mem_rd) rd_cyc++;
         if (mc_done) break;
      end
      n_chk++; if (ticks + 1 !== 8) begin n_fail++; $display("FAIL ab_len got %0d want 8", ticks + 1); end
      n_chk++; if (t3 !== 5) begin n_fail++; $display("FAIL ab_t3 got %0d want 5", t3); end
      n_chk++; if (rd_cyc !== 6) begin n_fail++; $display("FAIL ab_strobe got %0d want 6", rd_cyc); end
      n_chk++; if ({mc_done, bus_err, mem_rd} !== 3'b110) begin n_fail++; $display("FAIL ab_t4 got %b want 110", {mc_done, bus_err, mem_rd}); end
      n_chk++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL ab_data got %h want ff", cpu_rdata); end
      tick();
      mem_ready = 1'b1;
      n_chk++; if ({t_state, bus_err} !== 3'b000) begin n_fail++; $display("FAIL ab_end got %b want 000", {t_state, bus_err}); end
   endtask

   task automatic test_reset_mid();
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h2222; cpu_wdata = 8'h11; mem_ready = 1'b0;
      tick();
      cpu_req = 1'b0;
      tick();
      tick();
      n_chk++; if ({t_state, mem_wr} !== 3'b101) begin n_fail++; $display("FAIL rm_pre got %b want 101", {t_state, mem_wr}); end
      #2 rst = 1'b1;
      #1;
      n_chk++; if ({t_state, mem_wr} !== 3'b000) begin n_fail++; $display("FAIL rm_async got %b want 000", {t_state, mem_wr}); end
      n_chk++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rm_rdata got %h want 00", cpu_rdata); end
      tick();
      n_chk++; if ({t_state, mc_done, bus_err} !== 4'b0000) begin n_fail++; $display("FAIL rm_held got %b want 0000", {t_state, mc_done, bus_err}); end
      mem_ready = 1'b1;
      #2 rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_chk++; if (t_state !== 2'(i % 4)) begin n_fail++; $display("FAIL rm_seq[%0d] got %0d want %0d", i, t_state, i % 4); end
         n_chk++; if (mc_done !== (i == 3)) begin n_fail++; $display("FAIL rm_done[%0d] got %b want %b", i, mc_done, (i == 3)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  exp_t[8]    = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [15:0] exp_a[8]    = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0101, 16'h0101, 16'h0101, 16'h0101};
      logic        exp_rd[8]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        exp_wr[8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        exp_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0100; mem_rdata = 8'hC3; mem_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         tick();
         if (j == 0) begin cpu_write = 1'b1; cpu_addr = 16'h0101; cpu_wdata = 8'hAA; end
         if (j == 4) cpu_req = 1'b0;
         n_chk++; if (t_state !== exp_t[j]) begin n_fail++; $display("FAIL b2b_t[%0d] got %0d want %0d", j, t_state, exp_t[j]); end
         n_chk++; if (mem_addr !== exp_a[j]) begin n_fail++; $display("FAIL b2b_addr[%0d] got %h want %h", j, mem_addr, exp_a[j]); end
         n_chk++; if ({mem_rd, mem_wr, mc_done} !== {exp_rd[j], exp_wr[j], exp_done[j]}) begin
            n_fail++; $display("FAIL b2b_ctl[%0d] got %b want %b", j, {mem_rd, mem_wr, mc_done}, {exp_rd[j], exp_wr[j], exp_done[j]});
         end
         if (j == 2) begin
            n_chk++; if (cpu_rdata !== 8'hC3) begin n_fail++; $display("FAIL b2b_rdata got %h want c3", cpu_rdata); end
         end
         if (j == 5) begin
            n_chk++; if (mem_wdata !== 8'hAA) begin n_fail++; $display("FAIL b2b_wdata got %h want aa", mem_wdata); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_read();
      test_write_wait();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
